// File: rtl/arb_pkg.sv
// arb_pkg: shared source ids and output-register state for the 2:1 round-robin arbiter
package arb_pkg;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/rr_pick_2.sv
// rr_pick_2: combinational two-way round-robin pick; on a tie the source not granted last wins
module rr_pick_2
  import arb_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic win_valid,
  output logic win_id
);
  assign win_valid = a_valid | b_valid;
  assign win_id    = (a_valid & b_valid) ? ~last_grant : (b_valid ? SRC_B : SRC_A);
endmodule

// File: rtl/rr_arb_2to1.sv
// rr_arb_2to1: round-robin merge of two valid/ready sources into one output register
// with per-source accept counters
module rr_arb_2to1
  import arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d, last_q, last_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic              win_valid, win_id, accept;
  rr_pick_2 u_pick (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_q),
    .win_valid  (win_valid),
    .win_id     (win_id)
  );
  // rst_n gates accept so nothing is handshaken or counted in a reset cycle
  always_comb begin
    accept  = rst_n && (state_q == EMPTY || out_ready) && win_valid;
    state_d = accept ? FULL : (out_ready ? EMPTY : state_q);
    data_d  = accept ? (win_id == SRC_B ? b_data : a_data) : data_q;
    src_d   = accept ? win_id : src_q;
    last_d  = accept ? win_id : last_q;
    cnt_a_d = (accept && win_id == SRC_A) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
    cnt_b_d = (accept && win_id == SRC_B) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= SRC_A;
      last_q  <= SRC_B;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end
  assign a_ready   = accept && win_id == SRC_A;
  assign b_ready   = accept && win_id == SRC_B;
  assign out_valid = state_q == FULL;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;
endmodule

// File: tb/tb_rr_arb_2to1.sv
// tb_rr_arb_2to1: directed scenario tasks for rr_arb_2to1, plus a CNT_W=2 copy for counter wrap
module tb_rr_arb_2to1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, out_valid, out_src;
  logic [7:0] out_data, cnt_a, cnt_b;
  logic w_a_ready, w_b_ready, w_out_valid, w_out_src;
  logic [7:0] w_out_data;
  logic [1:0] w_cnt_a, w_cnt_b;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arb_2to1 #(.DATA_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  rr_arb_2to1 #(.DATA_W(8), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(w_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(w_b_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_src(w_out_src), .out_ready(out_ready),
    .cnt_a(w_cnt_a), .cnt_b(w_cnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'h55; b_data = 8'h66;
    rst_n = 1'b0;
    step();
    tests++; if ({a_ready, b_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", {a_ready, b_ready}); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if ({out_data, out_src} !== 9'h0) begin fails++; $display("FAIL reset_data_src got %h/%b want 00/0", out_data, out_src); end
    tests++; if ({cnt_a, cnt_b} !== 16'h0) begin fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", cnt_a, cnt_b); end
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_data = 8'h11; out_ready = 1'b1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b10) begin fails++; $display("FAIL a_only_ready got %b want 10", {a_ready, b_ready}); end
    step();
    a_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL a_only_valid got %b want 1", out_valid); end
    tests++; if (out_data !== 8'h11) begin fails++; $display("FAIL a_only_data got %h want 11", out_data); end
    tests++; if (out_src !== 1'b0) begin fails++; $display("FAIL a_only_src got %b want 0", out_src); end
    tests++; if (cnt_a !== 8'd1) begin fails++; $display("FAIL a_only_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_drain();
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 8'h11) begin fails++; $display("FAIL drain_hold got %h want 11", out_data); end
  endtask

  task automatic test_b_only();
    b_valid = 1'b1; b_data = 8'h22; out_ready = 1'b1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b01) begin fails++; $display("FAIL b_only_ready got %b want 01", {a_ready, b_ready}); end
    step();
    b_valid = 1'b0;
    tests++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, 8'h22}) begin fails++; $display("FAIL b_only_out got v%b s%b d%h want v1 s1 d22", out_valid, out_src, out_data); end
    tests++; if ({cnt_a, cnt_b} !== {8'd1, 8'd1}) begin fails++; $display("FAIL b_only_cnt got %0d/%0d want 1/1", cnt_a, cnt_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'hA0 + 8'(i);
      b_data = 8'hB0 + 8'(i);
      step();
      tests++; if (out_src !== 1'(i % 2)) begin fails++; $display("FAIL b2b_src[%0d] got %b want %0d", i, out_src, i % 2); end
      tests++; if (out_data !== ((i % 2) ? 8'hB0 + 8'(i) : 8'hA0 + 8'(i))) begin fails++; $display("FAIL b2b_data[%0d] got %h", i, out_data); end
    end
    tests++; if ({cnt_a, cnt_b} !== {8'd3, 8'd3}) begin fails++; $display("FAIL b2b_cnt got %0d/%0d want 3/3", cnt_a, cnt_b); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    a_data = 8'hC0; b_data = 8'hD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({a_ready, b_ready} !== 2'b00) begin fails++; $display("FAIL stall_ready[%0d] got %b want 00", i, {a_ready, b_ready}); end
      step();
      tests++; if ({out_valid, out_data} !== {1'b1, 8'hB5}) begin fails++; $display("FAIL stall_hold[%0d] got v%b d%h want v1 dB5", i, out_valid, out_data); end
      tests++; if ({cnt_a, cnt_b} !== {8'd3, 8'd3}) begin fails++; $display("FAIL stall_cnt[%0d] got %0d/%0d want 3/3", i, cnt_a, cnt_b); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b10) begin fails++; $display("FAIL stall_release got %b want 10", {a_ready, b_ready}); end
    step();
    tests++; if ({out_src, out_data} !== {1'b0, 8'hC0}) begin fails++; $display("FAIL stall_next got s%b d%h want s0 dC0", out_src, out_data); end
  endtask

  task automatic test_wrap();
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset();
    a_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = 8'(i);
      step();
      tests++; if (w_cnt_a !== 2'((i + 1) % 4)) begin fails++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, w_cnt_a, (i + 1) % 4); end
    end
    tests++; if (cnt_a !== 8'd5) begin fails++; $display("FAIL wrap_wide_cnt got %0d want 5", cnt_a); end
    a_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'hE1; b_data = 8'hF1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b00) begin fails++; $display("FAIL mid_rst_ready got %b want 00", {a_ready, b_ready}); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    tests++; if ({cnt_a, cnt_b} !== 16'h0) begin fails++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", cnt_a, cnt_b); end
    rst_n = 1'b1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b10) begin fails++; $display("FAIL mid_rst_tie got %b want 10", {a_ready, b_ready}); end
    step();
    tests++; if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 8'hE1}) begin fails++; $display("FAIL mid_rst_first got v%b s%b d%h want v1 s0 dE1", out_valid, out_src, out_data); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_drain();
    test_b_only();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_arb_2to1.md
RR_ARB_2TO1 -- requirements
Module: rr_arb_2to1

Interface
REQ-001 Parameter: DATA_W, default 8, width of each data path.
REQ-002 Parameter: CNT_W, default 8, width of each per-source grant counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 a_valid  input  1  source A offers a word.
REQ-006 a_data  input  DATA_W  source A word.
REQ-007 a_ready  output  1  source A word accepted this cycle when a_valid and a_ready are both high.
REQ-008 b_valid  input  1  source B offers a word.
REQ-009 b_data  input  DATA_W  source B word.
REQ-010 b_ready  output  1  source B word accepted this cycle when b_valid and b_ready are both high.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  DATA_W  registered selected word.
REQ-013 out_src  output  1  source of out_data: 0 = A, 1 = B; usable directly as a downstream 2:1 select.
REQ-014 out_ready  input  1  consumer takes out_data when out_valid and out_ready are both high.
REQ-015 cnt_a, cnt_b  output  CNT_W each  number of accepted A / B words, wrapping modulo 2^CNT_W.

Function
REQ-016 FSM states: EMPTY (out_valid=0) and FULL (out_valid=1); out_valid SHALL equal (state == FULL).
REQ-017 can_load = EMPTY, or FULL with out_ready=1.
REQ-018 Arbitration (combinational, same cycle):
- A valid only -> A wins.
- B valid only -> B wins.
- Both valid -> winner is the source not equal to last_grant.
- Neither valid -> no winner.
REQ-019 a_ready = can_load and winner==A; b_ready = can_load and winner==B; never both high; ready SHALL NOT depend on the same source's valid except through arbitration.
REQ-020 On accept, next edge: out_data <= winner data, out_src <= winner id, last_grant <= winner id, winner counter +1, state <= FULL.
REQ-021 Latency: accepted word appears on out_data exactly 1 cycle after the accept edge.
REQ-022 Throughput: 1 word/cycle while out_ready=1 (consume and reload in the same cycle).
REQ-023 FULL with out_ready=1 and no winner -> EMPTY; out_data and out_src hold their last values.
REQ-024 FULL with out_ready=0 -> out_data, out_src, last_grant and counters hold; a_ready=b_ready=0.
REQ-025 Counter at 2^CNT_W-1 plus an accept -> 0; no flag.
REQ-026 last_grant changes only on accept, so sustained contention alternates A,B,A,B.

Reset
REQ-027 rst_n=0 at a rising edge -> next cycle: state=EMPTY, out_valid=0, out_data=0, out_src=0, cnt_a=0, cnt_b=0, last_grant=1 (A wins the first tie).
REQ-028 During reset, a_ready=b_ready=0; any in-flight word is discarded, and no accept is counted in the reset cycle.
REQ-029 Reset SHALL be sampled only on clk edges; no asynchronous path.

Structure
REQ-030 Shared package arb_pkg: constants SRC_A=0 and SRC_B=1, and state enum {EMPTY, FULL}.
REQ-031 One sub-module rr_pick_2 (pure combinational: a_valid, b_valid, last_grant -> win_valid, win_id); the top holds all registers.

Verification
REQ-032 Reset, then A-only 0x11 with out_ready=1 -> a_ready=1; next cycle out_valid=1, out_data=0x11, out_src=0, cnt_a=1.
REQ-033 Both valid every cycle (A=0xA0.., B=0xB0..), out_ready=1, 6 cycles -> out_src sequence 0,1,0,1,0,1; cnt_a=cnt_b=3.
REQ-034 FULL with out_ready=0 for 3 cycles while both valid -> a_ready=b_ready=0; out_data stable; counters unchanged.
REQ-035 out_ready=1 in FULL with no source valid -> out_valid=0 next cycle; out_data holds its prior value.
REQ-036 CNT_W=2, 5 A-only accepts -> cnt_a sequence 1,2,3,0,1.
REQ-037 rst_n=0 in FULL mid-stream while both sources are valid -> next cycle out_valid=0, counters 0; first post-reset tie goes to A.
